// File: rtl/ssd_accel_display.sv
// Purpose : accelerometer sample -> signed/unsigned decimal (double dabble) or hex,
//           scanned onto a 4-digit common-anode active-low seven-segment display.
// Latency : decimal 10 cycles, hex 2 cycles from capture to digit-register write;
//           SEG/DP/AN follow one cycle later.
// Backpressure: none; an event while busy is held in a one-deep pending slot and
//           a newer event overwrites it.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   DATA_IN[7:0]        sample, captured on the rising edge of DATA_VALID
//   DATA_VALID          level strobe; only its 0->1 transition starts a conversion
//   HEX_MODE            0 decimal, 1 hex; latched together with DATA_IN
//   SEG[6:0], DP, AN[3:0]  active-low segments {g..a}, decimal point, digit enables
//   BUSY                high while a conversion (or a chain of them) is in flight
module ssd_accel_display #(
  parameter int REFRESH_DIVIDE = 31250,
  parameter bit SIGNED_MODE    = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  input  logic       HEX_MODE,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN,
  output logic       BUSY
);

  localparam int              CNT_W      = (REFRESH_DIVIDE > 2) ? $clog2(REFRESH_DIVIDE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIVIDE - 1);
  // Digit codes are stored as {dp, seg[6:0]}, all active-low.
  localparam logic [7:0]      CODE_BLANK = 8'hFF;
  localparam logic [6:0]      SEG_MINUS  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  state_t           state, state_n;
  logic             dv_q, capture;
  logic [7:0]       cur_dat;
  logic             cur_hex;
  logic             pend_vld;
  logic [7:0]       pend_dat;
  logic             pend_hex;
  logic             neg;
  logic [7:0]       mag;
  logic [11:0]      bcd, bcd_adj;
  logic [3:0]       shift_cnt;
  logic [3:0][7:0]  dig, dig_n;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       scan_idx, scan_idx_n;
  logic             wrap;

  assign capture = DATA_VALID & ~dv_q;
  assign BUSY    = (state != IDLE);

  // ---------------- control FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (capture) state_n = LOAD;
      LOAD:    state_n = cur_hex ? DONE : SHIFT;
      SHIFT:   if (shift_cnt == 4'd1) state_n = DONE;
      // An event landing in DONE is taken directly; it supersedes any older pending one.
      DONE:    state_n = (capture || pend_vld) ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------- conversion datapath ----------------
  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    dig_n = {4{CODE_BLANK}};
    if (cur_hex) begin
      dig_n[1] = {1'b1, seg_of(cur_dat[7:4])};
      dig_n[0] = {1'b0, seg_of(cur_dat[3:0])};
    end else begin
      dig_n[3] = neg ? {1'b1, SEG_MINUS} : CODE_BLANK;
      dig_n[2] = (bcd[11:8] != 4'd0) ? {1'b1, seg_of(bcd[11:8])} : CODE_BLANK;
      // Tens is suppressed only when it is a leading zero.
      dig_n[1] = (bcd[11:4] != 8'd0) ? {1'b1, seg_of(bcd[7:4])} : CODE_BLANK;
      dig_n[0] = {1'b1, seg_of(bcd[3:0])};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dv_q      <= 1'b0;
      cur_dat   <= 8'd0;
      cur_hex   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_dat  <= 8'd0;
      pend_hex  <= 1'b0;
      neg       <= 1'b0;
      mag       <= 8'd0;
      bcd       <= 12'd0;
      shift_cnt <= 4'd0;
      dig       <= {4{CODE_BLANK}};
    end else begin
      dv_q <= DATA_VALID;
      if (capture && (state == LOAD || state == SHIFT)) begin
        pend_vld <= 1'b1;
        pend_dat <= DATA_IN;
        pend_hex <= HEX_MODE;
      end
      case (state)
        IDLE: begin
          if (capture) begin
            cur_dat <= DATA_IN;
            cur_hex <= HEX_MODE;
          end
        end
        LOAD: begin
          // 9-bit negation so that 0x80 yields a magnitude of 128.
          if (SIGNED_MODE && cur_dat[7]) begin
            neg <= 1'b1;
            mag <= 8'(9'd0 - {1'b1, cur_dat});
          end else begin
            neg <= 1'b0;
            mag <= cur_dat;
          end
          bcd       <= 12'd0;
          shift_cnt <= 4'd8;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          shift_cnt  <= shift_cnt - 4'd1;
        end
        DONE: begin
          dig <= dig_n;
          if (capture) begin
            cur_dat  <= DATA_IN;
            cur_hex  <= HEX_MODE;
            pend_vld <= 1'b0;
          end else if (pend_vld) begin
            cur_dat  <= pend_dat;
            cur_hex  <= pend_hex;
            pend_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- display scan ----------------
  assign wrap       = (refresh_cnt == CNT_LAST);
  assign scan_idx_n = wrap ? scan_idx + 2'd1 : scan_idx;

  // AN only moves on a wrap, so it stays all-off until the first slot completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      refresh_cnt <= '0;
      scan_idx    <= 2'd3;
      AN          <= 4'hF;
      SEG         <= 7'h7F;
      DP          <= 1'b1;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      scan_idx    <= scan_idx_n;
      if (wrap) AN <= ~(4'b0001 << scan_idx_n);
      SEG <= dig[scan_idx_n][6:0];
      DP  <= dig[scan_idx_n][7];
    end
  end

endmodule

// File: tb/tb_ssd_accel_display.sv
// Purpose : self-checking bench for ssd_accel_display (signed and unsigned instances).
// Latency : expectations are queued at stimulus time and consumed when BUSY falls.
// Backpressure: stimulus waits for both monitors to drain before the next event.
module tb_ssd_accel_display;

  localparam int RD = 8;

  typedef struct packed {
    logic [3:0][7:0] dig;   // {dp, seg} per digit, index 0 = rightmost
    logic [7:0]      blen;  // expected BUSY high cycles
  } exp_t;

  logic       CLK;
  logic       RST;
  logic [7:0] DATA_IN;
  logic       DATA_VALID;
  logic       HEX_MODE;
  logic [6:0] seg_s, seg_u;
  logic       dp_s, dp_u;
  logic [3:0] an_s, an_u;
  logic       busy_s, busy_u;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_exp    = 0;
  int   done_cnt [2];
  exp_t q_s[$];
  exp_t q_u[$];

  ssd_accel_display #(.REFRESH_DIVIDE(RD), .SIGNED_MODE(1'b1)) u_dut_s (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID), .HEX_MODE(HEX_MODE),
    .SEG(seg_s), .DP(dp_s), .AN(an_s), .BUSY(busy_s)
  );

  ssd_accel_display #(.REFRESH_DIVIDE(RD), .SIGNED_MODE(1'b0)) u_dut_u (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID), .HEX_MODE(HEX_MODE),
    .SEG(seg_u), .DP(dp_u), .AN(an_u), .BUSY(busy_u)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
     12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
     15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: plain integer arithmetic on the sample value.
  function automatic exp_t model(input logic [7:0] v, input logic hex, input logic sgn);
    exp_t e;
    int   s, m;
    e.dig = {4{8'hFF}};
    if (hex) begin
      e.blen   = 8'd2;
      e.dig[1] = {1'b1, seg_of(int'(v) / 16)};
      e.dig[0] = {1'b0, seg_of(int'(v) % 16)};
    end else begin
      if (sgn) s = int'($signed(v));
      else     s = int'(v);
      m = (s < 0) ? -s : s;
      e.blen = 8'd10;
      if (s < 0)   e.dig[3] = {1'b1, 7'b0111111};
      if (m >= 100) e.dig[2] = {1'b1, seg_of(m / 100)};
      if (m >= 10)  e.dig[1] = {1'b1, seg_of((m / 10) % 10)};
      e.dig[0] = {1'b1, seg_of(m % 10)};
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input exp_t es, input exp_t eu);
    q_s.push_back(es);
    q_u.push_back(eu);
    n_exp++;
  endtask

  // Called at a negedge; the event is sampled on the next posedge.
  task automatic pulse_event(input logic [7:0] v, input logic hex);
    DATA_IN    = v;
    HEX_MODE   = hex;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((done_cnt[0] < n_exp || done_cnt[1] < n_exp) && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    n_checks++;
    if (t >= 1000) begin
      n_fail++;
      $display("FAIL wait_done: monitors finished %0d/%0d of %0d conversions", done_cnt[0], done_cnt[1], n_exp);
    end
  endtask

  task automatic run_one(input logic [7:0] v, input logic hex);
    push_exp(model(v, hex, 1'b1), model(v, hex, 1'b0));
    pulse_event(v, hex);
    wait_done();
  endtask

  // Monitor: measures each BUSY pulse, then watches one full scan and compares digits.
  task automatic monitor(input int u);
    int         len = 0;
    int         slot;
    exp_t       e;
    logic [7:0] obs;
    logic [3:0] an_m;
    bit         got  [4];
    bit         bad  [4];
    logic [7:0] badv [4];
    forever begin
      @(negedge CLK);
      if ((u == 0) ? busy_s : busy_u) begin
        len++;
      end else if (len != 0) begin
        if (((u == 0) ? q_s.size() : q_u.size()) == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_conversion dut%0d: busy pulse of %0d cycles, required none", u, len);
        end else begin
          if (u == 0) e = q_s.pop_front();
          else        e = q_u.pop_front();
          check($sformatf("busy_len_dut%0d", u), len, 32'(e.blen));
          for (int d = 0; d < 4; d++) begin
            got[d] = 1'b0; bad[d] = 1'b0; badv[d] = 8'h00;
          end
          repeat (2) @(negedge CLK);
          for (int c = 0; c < 5 * RD; c++) begin
            an_m = (u == 0) ? an_s : an_u;
            case (an_m)
              4'b1110: slot = 0;
              4'b1101: slot = 1;
              4'b1011: slot = 2;
              4'b0111: slot = 3;
              default: slot = -1;
            endcase
            if (slot >= 0) begin
              got[slot] = 1'b1;
              obs = (u == 0) ? {dp_s, seg_s} : {dp_u, seg_u};
              if (obs !== e.dig[slot]) begin
                bad[slot]  = 1'b1;
                badv[slot] = obs;
              end
            end
            @(negedge CLK);
          end
          for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (!got[d] || bad[d]) begin
              n_fail++;
              $display("FAIL digit%0d_dut%0d: got {dp,seg}=%b (shown=%0d), required %b",
                       d, u, badv[d], got[d], e.dig[d]);
            end
          end
          done_cnt[u]++;
        end
        len = 0;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    exp_t       es, eu;
    logic [3:0] exp_an;
    logic [7:0] rv;
    logic       rh;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    RST        = 1'b1;
    DATA_IN    = 8'd0;
    DATA_VALID = 1'b0;
    HEX_MODE   = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Reset state and blank scan pattern.
    for (int k = 0; k < 6 * RD; k++) begin
      exp_an = (k < RD) ? 4'hF : ~(4'b0001 << ((k / RD - 1) % 4));
      check($sformatf("reset_scan_s_c%0d", k), {an_s, seg_s, dp_s, busy_s}, {exp_an, 7'h7F, 1'b1, 1'b0});
      check($sformatf("reset_scan_u_c%0d", k), {an_u, seg_u, dp_u, busy_u}, {exp_an, 7'h7F, 1'b1, 1'b0});
      @(negedge CLK);
    end

    // Directed corner values.
    run_one(8'h7F, 1'b0);
    run_one(8'h80, 1'b0);
    run_one(8'hFF, 1'b0);
    run_one(8'h00, 1'b0);
    run_one(8'hA5, 1'b1);

    // Second rising edge during SHIFT: one continuous BUSY, final value shown.
    es = model(8'h05, 1'b0, 1'b1); es.blen = 8'd20;
    eu = model(8'h05, 1'b0, 1'b0); eu.blen = 8'd20;
    push_exp(es, eu);
    pulse_event(8'h10, 1'b0);
    repeat (3) @(negedge CLK);
    pulse_event(8'h05, 1'b0);
    wait_done();

    // Event landing in the DONE cycle is chained straight on.
    es = model(8'h99, 1'b1, 1'b1); es.blen = 8'd12;
    eu = model(8'h99, 1'b1, 1'b0); eu.blen = 8'd12;
    push_exp(es, eu);
    pulse_event(8'h42, 1'b0);
    repeat (9) @(negedge CLK);
    pulse_event(8'h99, 1'b1);
    wait_done();

    // Sustained level: exactly one conversion.
    push_exp(model(8'h10, 1'b0, 1'b1), model(8'h10, 1'b0, 1'b0));
    DATA_IN    = 8'h10;
    HEX_MODE   = 1'b0;
    DATA_VALID = 1'b1;
    repeat (5000) @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_done();
    repeat (20) @(negedge CLK);

    // Reset during SHIFT: conversion aborted, display blank.
    es.dig = {4{8'hFF}}; es.blen = 8'd4;
    push_exp(es, es);
    pulse_event(8'h63, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midreset_s", {busy_s, an_s, seg_s}, {1'b0, 4'hF, 7'h7F});
    check("midreset_u", {busy_u, an_u, seg_u}, {1'b0, 4'hF, 7'h7F});
    wait_done();

    // Randomized samples and modes.
    for (int i = 0; i < 12; i++) begin
      rv = 8'($urandom_range(0, 255));
      rh = 1'($urandom_range(0, 1));
      run_one(rv, rh);
    end

    repeat (20) @(negedge CLK);
    check("conversions_dut0", done_cnt[0], n_exp);
    check("conversions_dut1", done_cnt[1], n_exp);
    check("queues_empty", q_s.size() + q_u.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
